// File: rtl/mem_wb_pipe_if.sv
// MEM->WB pipeline bus: MEM-stage instruction fields in, last-stage write-back fields out.
interface mem_wb_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_pred;
    logic [DATA_W-1:0]  in_data;
    logic [RADDR_W-1:0] in_rw;
    logic               in_regwrite;
    logic               in_regsel;

    logic               out_valid;
    logic               out_pred;
    logic [DATA_W-1:0]  out_data;
    logic [RADDR_W-1:0] out_rw;
    logic               out_regwrite;
    logic               out_regsel;

    // Memory-stage side: drives the instruction, observes write-back
    modport master (
        output in_valid, in_pred, in_data, in_rw, in_regwrite, in_regsel,
        input  out_valid, out_pred, out_data, out_rw, out_regwrite, out_regsel
    );

    // Pipeline register side
    modport slave (
        input  in_valid, in_pred, in_data, in_rw, in_regwrite, in_regsel,
        output out_valid, out_pred, out_data, out_rw, out_regwrite, out_regsel
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register chain with predicated commit, stall/flush,
// two combinational forwarding lookups and a saturating annul counter.
module mem_wb_pipe #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int DEPTH    = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    mem_wb_pipe_if.slave       bus,
    input  logic [RADDR_W-1:0] fwd_addr_a,
    input  logic [RADDR_W-1:0] fwd_addr_b,
    output logic               fwd_hit_a,
    output logic               fwd_hit_b,
    output logic [DATA_W-1:0]  fwd_data_a,
    output logic [DATA_W-1:0]  fwd_data_b,
    output logic [CNT_W-1:0]   annul_cnt
);
    localparam int unsigned LAST = DEPTH - 1;

    logic [DEPTH-1:0]   v_q;
    logic [DEPTH-1:0]   p_q;
    logic [DEPTH-1:0]   we_q;
    logic [DEPTH-1:0]   sel_q;
    logic [DATA_W-1:0]  d_q  [DEPTH];
    logic [RADDR_W-1:0] rw_q [DEPTH];

    logic we_in;
    logic annul_ev;

    // Entry write enable and predicate-annul event for the incoming instruction
    always_comb begin
        we_in    = bus.in_valid & bus.in_regwrite & bus.in_pred &
                   ~(ZERO_REG & (bus.in_rw == '0));
        annul_ev = bus.in_valid & bus.in_regwrite & ~bus.in_pred;
    end

    // Stage chain: reset and flush both clear, stall holds, otherwise shift
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v_q   <= '0;
            p_q   <= '0;
            we_q  <= '0;
            sel_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                d_q[k]  <= '0;
                rw_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q[0]   <= bus.in_valid;
            p_q[0]   <= bus.in_pred;
            we_q[0]  <= we_in;
            sel_q[0] <= bus.in_regsel;
            d_q[0]   <= bus.in_data;
            rw_q[0]  <= bus.in_rw;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                v_q[k]   <= v_q[k-1];
                p_q[k]   <= p_q[k-1];
                we_q[k]  <= we_q[k-1];
                sel_q[k] <= sel_q[k-1];
                d_q[k]   <= d_q[k-1];
                rw_q[k]  <= rw_q[k-1];
            end
        end
    end

    // Annul counter: cleared only by reset, counts on advance cycles, saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            annul_cnt <= '0;
        end else if (!flush && !stall && annul_ev && (annul_cnt != '1)) begin
            annul_cnt <= annul_cnt + 1'b1;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match overwrites
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (v_q[LAST-k] && we_q[LAST-k] && (rw_q[LAST-k] == fwd_addr_a) &&
                !(ZERO_REG && (fwd_addr_a == '0))) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = d_q[LAST-k];
            end
            if (v_q[LAST-k] && we_q[LAST-k] && (rw_q[LAST-k] == fwd_addr_b) &&
                !(ZERO_REG && (fwd_addr_b == '0))) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = d_q[LAST-k];
            end
        end
    end

    // Write-back outputs come straight from the last stage
    always_comb begin
        bus.out_valid    = v_q[LAST];
        bus.out_pred     = p_q[LAST];
        bus.out_data     = d_q[LAST];
        bus.out_rw       = rw_q[LAST];
        bus.out_regwrite = we_q[LAST];
        bus.out_regsel   = sel_q[LAST];
    end
endmodule
